// File: rtl/axis_header_inserter.sv
// Prepends a HEADER_LENGTH_BYTES header to each AXI-Stream packet and repacks the payload.
// Define AXIS_HEADER_INSERTER_TUSER_EN to forward tuser; otherwise axis_o_tuser is tied 0.
module axis_header_inserter #(
    parameter int unsigned AXIS_BYTES          = 1,
    parameter int unsigned AXIS_USER_BITS      = 1,
    parameter int unsigned HEADER_LENGTH_BYTES = 1
) (
    input  logic                             clk,
    input  logic                             areset,
    input  logic [HEADER_LENGTH_BYTES*8-1:0] header_i,
    input  logic                             header_i_tvalid,
    output logic                             header_i_tready,
    output logic                             axis_i_tready,
    input  logic                             axis_i_tvalid,
    input  logic                             axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]          axis_i_tdata,
    input  logic [AXIS_BYTES-1:0]            axis_i_tkeep,
    input  logic [AXIS_USER_BITS-1:0]        axis_i_tuser,
    input  logic                             axis_o_tready,
    output logic                             axis_o_tvalid,
    output logic                             axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]          axis_o_tdata,
    output logic [AXIS_BYTES-1:0]            axis_o_tkeep,
    output logic [AXIS_USER_BITS-1:0]        axis_o_tuser
);

`ifdef AXIS_HEADER_INSERTER_TUSER_EN
    localparam bit UserEn = 1'b1;
`else
    localparam bit UserEn = 1'b0;
`endif

    localparam int B     = int'(AXIS_BYTES);
    localparam int H     = int'(HEADER_LENGTH_BYTES);
    localparam int DW    = B * 8;
    localparam int R     = H % B;
    localparam int F     = H / B;
    localparam int CW    = (R == 0) ? 1 : R;
    localparam int CNT_W = $clog2(F + 2);
    localparam int NW    = 2 ** CNT_W;
    localparam int HPW   = NW * DW;

    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StFlush} state_e;

    state_e                    state_q, state_d;
    logic [H*8-1:0]            hdr_q, hdr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CW*8-1:0]           carry_q, carry_d;
    logic [B-1:0]              flush_keep_q, flush_keep_d;
    logic [AXIS_USER_BITS-1:0] user_last_q, user_last_d;

    logic                      o_valid_q, o_last_q;
    logic [DW-1:0]             o_data_q;
    logic [B-1:0]              o_keep_q;
    logic [AXIS_USER_BITS-1:0] o_user_q;

    logic                      out_ready, load, w_last;
    logic [DW-1:0]             w_data, data_m, hdr_word, shifted;
    logic [B-1:0]              w_keep;
    logic [AXIS_USER_BITS-1:0] w_user;
    logic [HPW-1:0]            hdr_pad;
    int                        k, n;

    function automatic logic [AXIS_BYTES-1:0] keep_mask(input int cnt);
        logic [AXIS_BYTES-1:0] m;
        for (int i = 0; i < B; i++) m[i] = (i < cnt);
        return m;
    endfunction

    assign out_ready       = !o_valid_q || axis_o_tready;
    assign header_i_tready = (state_q == StIdle) && !areset;
    assign axis_i_tready   = (state_q == StPayload) && out_ready && !areset;

    // In IDLE the first header word comes straight from header_i so it loads on acceptance.
    always_comb begin
        hdr_pad  = HPW'((state_q == StIdle) ? header_i : hdr_q);
        hdr_word = '0;
        for (int i = 0; i < NW; i++) begin
            if (i == int'(cnt_q)) hdr_word = hdr_pad[i*DW +: DW];
        end
    end

    assign shifted = (axis_i_tdata << (R * 8)) | DW'(carry_q);

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        flush_keep_d = flush_keep_q;
        user_last_d  = user_last_q;
        load         = 1'b0;
        w_data       = '0;
        w_keep       = '0;
        w_last       = 1'b0;
        w_user       = '0;
        k            = 0;
        for (int i = 0; i < B; i++) begin
            if (axis_i_tkeep[i]) k = k + 1;
        end
        n = R + k;

        unique case (state_q)
            StIdle: begin
                if (header_i_tvalid) begin
                    hdr_d       = header_i;
                    cnt_d       = '0;
                    user_last_d = '0;
                    if (R != 0) carry_d = header_i[H*8-1 -: CW*8];
                    if (F == 0) begin
                        state_d = StPayload;
                    end else if (out_ready) begin
                        load   = 1'b1;
                        w_data = hdr_word;
                        w_keep = '1;
                        if (F == 1) begin
                            state_d = StPayload;
                        end else begin
                            state_d = StHeader;
                            cnt_d   = CNT_W'(1);
                        end
                    end else begin
                        state_d = StHeader;
                    end
                end
            end
            StHeader: begin
                if (out_ready) begin
                    load   = 1'b1;
                    w_data = hdr_word;
                    w_keep = '1;
                    if (int'(cnt_q) + 1 == F) begin
                        state_d = StPayload;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StPayload: begin
                if (axis_i_tvalid && out_ready) begin
                    load        = 1'b1;
                    user_last_d = axis_i_tuser;
                    w_user      = axis_i_tuser;
                    if (R == 0) begin
                        w_data = axis_i_tdata;
                        w_keep = axis_i_tkeep;
                        w_last = axis_i_tlast;
                        if (axis_i_tlast) state_d = StIdle;
                    end else begin
                        w_data  = shifted;
                        w_keep  = '1;
                        carry_d = axis_i_tdata[DW-1 -: CW*8];
                        if (axis_i_tlast) begin
                            if (n <= B) begin
                                w_keep  = keep_mask(n);
                                w_last  = 1'b1;
                                state_d = StIdle;
                                // An empty last beat contributes no byte, so its tuser does not apply.
                                if (k == 0) w_user = user_last_q;
                            end else begin
                                flush_keep_d = keep_mask(n - B);
                                state_d      = StFlush;
                            end
                        end
                    end
                end
            end
            StFlush: begin
                if (out_ready) begin
                    load    = 1'b1;
                    w_data  = DW'(carry_q);
                    w_keep  = flush_keep_q;
                    w_last  = 1'b1;
                    w_user  = user_last_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!UserEn) begin
            w_user      = '0;
            user_last_d = '0;
        end
    end

    always_comb begin
        data_m = '0;
        for (int i = 0; i < B; i++) begin
            if (w_keep[i]) data_m[i*8 +: 8] = w_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= StIdle;
            hdr_q        <= '0;
            cnt_q        <= '0;
            carry_q      <= '0;
            flush_keep_q <= '0;
            user_last_q  <= '0;
            o_valid_q    <= 1'b0;
            o_last_q     <= 1'b0;
            o_data_q     <= '0;
            o_keep_q     <= '0;
            o_user_q     <= '0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            flush_keep_q <= flush_keep_d;
            user_last_q  <= user_last_d;
            if (out_ready) begin
                o_valid_q <= load;
                if (load) begin
                    o_data_q <= data_m;
                    o_keep_q <= w_keep;
                    o_last_q <= w_last;
                    o_user_q <= w_user;
                end
            end
        end
    end

    assign axis_o_tvalid = o_valid_q;
    assign axis_o_tlast  = o_last_q;
    assign axis_o_tdata  = o_data_q;
    assign axis_o_tkeep  = o_keep_q;
    assign axis_o_tuser  = o_user_q;

endmodule
